// File: rtl/vga_text_overlay.sv
// rtl/vga_text_overlay.sv - text-mode overlay: character buffer, clear sweep, font lookup, cursor and border.

module font (
    input  logic       clk,
    input  logic [2:0] pos_x,
    input  logic [2:0] pos_y,
    input  logic [7:0] char_code,
    output logic       pixel
);
    // Glyphs are packed {row0..row7}; bit 7 of each row is the leftmost pixel.
    logic [63:0] glyph;

    always_comb begin
        glyph = 64'h0;
        case (char_code)
            8'h41:   glyph = 64'h183C_6666_7E66_6600;
            8'h42:   glyph = 64'h7C66_667C_6666_7C00;
            8'h43:   glyph = 64'h3C66_6060_6066_3C00;
            8'hDB:   glyph = 64'hFFFF_FFFF_FFFF_FFFF;
            default: glyph = 64'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        pixel <= glyph[{~pos_y, ~pos_x}];
    end
endmodule

module vga_text_overlay #(
    parameter int          COLS         = 40,
    parameter int          ROWS         = 30,
    parameter int          ZOOM         = 1,
    parameter int          BLINK_FRAMES = 30,
    parameter logic [2:0]  BORDER_RGB   = 3'b001,
    parameter int          AW           = $clog2(COLS*ROWS)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          hsync_in,
    input  logic          vsync_in,
    input  logic          active_in,
    input  logic [9:0]    px_x,
    input  logic [9:0]    px_y,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [10:0]   wr_data,
    input  logic          clr,
    output logic          busy,
    input  logic          cursor_en,
    input  logic [6:0]    cursor_col,
    input  logic [5:0]    cursor_row,
    output logic          hsync,
    output logic          vsync,
    output logic [2:0]    rgb
);
    localparam int            CELLS      = COLS * ROWS;
    localparam int            SH         = 3 + ZOOM;
    localparam logic [AW-1:0] LAST_ADDR  = AW'(CELLS - 1);
    localparam logic [9:0]    COLS_W     = 10'(COLS);
    localparam logic [9:0]    ROWS_W     = 10'(ROWS);
    localparam int            FW         = $clog2(BLINK_FRAMES + 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [10:0]   BLANK_CELL = 11'h720;

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] sweep_q, sweep_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_CLEAR;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        case (state_q)
            ST_IDLE: begin
                if (clr) begin
                    state_d = ST_CLEAR;
                    sweep_d = '0;
                end
            end
            ST_CLEAR: begin
                if (clr) begin
                    sweep_d = '0;
                end else if (sweep_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end else begin
                    sweep_d = sweep_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q == ST_CLEAR);

    // The sweep owns the single write port; host writes are simply dropped meanwhile.
    logic          mem_we;
    logic [AW-1:0] mem_wa;
    logic [10:0]   mem_wd;

    always_comb begin
        mem_we = busy | (wr_en & (wr_addr <= LAST_ADDR));
        mem_wa = busy ? sweep_q : wr_addr;
        mem_wd = busy ? BLANK_CELL : wr_data;
    end

    logic [10:0]   mem [CELLS];
    logic [10:0]   rd_data_q;
    logic [AW-1:0] s1_addr_q;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
        rd_data_q <= mem[s1_addr_q];
    end

    logic          phase_q, phase_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          s1_vs_q;

    always_comb begin
        phase_d = phase_q;
        frame_d = frame_q;
        if (s1_vs_q && !vsync_in) begin
            if (frame_q == FRAME_LAST) begin
                frame_d = '0;
                phase_d = ~phase_q;
            end else begin
                frame_d = frame_q + 1'b1;
            end
        end
    end

    logic [9:0]  col_c, row_c;
    logic [19:0] lin_c;
    logic        in_area_c, border_c, cur_hit_c;
    logic [2:0]  gx_c, gy_c;
    logic [AW-1:0] addr_c;

    always_comb begin
        col_c     = px_x >> SH;
        row_c     = px_y >> SH;
        in_area_c = active_in && (col_c < COLS_W) && (row_c < ROWS_W);
        lin_c     = 20'(row_c) * 20'(COLS) + 20'(col_c);
        addr_c    = in_area_c ? AW'(lin_c) : '0;
        gx_c      = 3'(px_x >> ZOOM);
        gy_c      = 3'(px_y >> ZOOM);
        border_c  = (px_x == 10'd0) || (px_x == 10'd639) || (px_y == 10'd0) || (px_y == 10'd479);
        cur_hit_c = in_area_c && cursor_en && phase_q &&
                    (col_c == {3'b000, cursor_col}) && (row_c == {4'b0000, cursor_row});
    end

    logic       s1_hs_q, s1_act_q, s1_area_q, s1_border_q, s1_cur_q;
    logic [2:0] s1_gx_q, s1_gy_q;
    logic       s2_hs_q, s2_vs_q, s2_act_q, s2_area_q, s2_border_q, s2_cur_q;
    logic [2:0] s2_gx_q, s2_gy_q;
    logic       s3_hs_q, s3_vs_q, s3_act_q, s3_border_q, s3_cur_q;
    logic [2:0] s3_fg_q;
    logic       hsync_q, vsync_q;
    logic [2:0] rgb_q, rgb_d;
    logic [7:0] char_c;
    logic [2:0] fg_c;
    logic       glyph_bit;

    assign char_c = s2_area_q ? rd_data_q[7:0]  : 8'h00;
    assign fg_c   = s2_area_q ? rd_data_q[10:8] : 3'b000;

    font u_font (
        .clk       (clk),
        .pos_x     (s2_gx_q),
        .pos_y     (s2_gy_q),
        .char_code (char_c),
        .pixel     (glyph_bit)
    );

    // The cursor inverts the glyph bit, so a lit glyph pixel under the cursor goes dark.
    always_comb begin
        rgb_d = 3'b000;
        if (s3_act_q) begin
            if (glyph_bit ^ s3_cur_q) begin
                rgb_d = s3_fg_q;
            end else if (s3_border_q) begin
                rgb_d = BORDER_RGB;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            phase_q     <= 1'b0;
            frame_q     <= '0;
            s1_hs_q     <= 1'b1;
            s1_vs_q     <= 1'b1;
            s1_act_q    <= 1'b0;
            s1_area_q   <= 1'b0;
            s1_border_q <= 1'b0;
            s1_cur_q    <= 1'b0;
            s1_gx_q     <= '0;
            s1_gy_q     <= '0;
            s1_addr_q   <= '0;
            s2_hs_q     <= 1'b1;
            s2_vs_q     <= 1'b1;
            s2_act_q    <= 1'b0;
            s2_area_q   <= 1'b0;
            s2_border_q <= 1'b0;
            s2_cur_q    <= 1'b0;
            s2_gx_q     <= '0;
            s2_gy_q     <= '0;
            s3_hs_q     <= 1'b1;
            s3_vs_q     <= 1'b1;
            s3_act_q    <= 1'b0;
            s3_border_q <= 1'b0;
            s3_cur_q    <= 1'b0;
            s3_fg_q     <= '0;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
            rgb_q       <= 3'b000;
        end else begin
            phase_q     <= phase_d;
            frame_q     <= frame_d;
            s1_hs_q     <= hsync_in;
            s1_vs_q     <= vsync_in;
            s1_act_q    <= active_in;
            s1_area_q   <= in_area_c;
            s1_border_q <= border_c;
            s1_cur_q    <= cur_hit_c;
            s1_gx_q     <= gx_c;
            s1_gy_q     <= gy_c;
            s1_addr_q   <= addr_c;
            s2_hs_q     <= s1_hs_q;
            s2_vs_q     <= s1_vs_q;
            s2_act_q    <= s1_act_q;
            s2_area_q   <= s1_area_q;
            s2_border_q <= s1_border_q;
            s2_cur_q    <= s1_cur_q;
            s2_gx_q     <= s1_gx_q;
            s2_gy_q     <= s1_gy_q;
            s3_hs_q     <= s2_hs_q;
            s3_vs_q     <= s2_vs_q;
            s3_act_q    <= s2_act_q;
            s3_border_q <= s2_border_q;
            s3_cur_q    <= s2_cur_q;
            s3_fg_q     <= fg_c;
            hsync_q     <= s3_hs_q;
            vsync_q     <= s3_vs_q;
            rgb_q       <= rgb_d;
        end
    end

    assign hsync = hsync_q;
    assign vsync = vsync_q;
    assign rgb   = rgb_q;
endmodule

// File: tb/tb_vga_text_overlay.sv
// tb/tb_vga_text_overlay.sv - directed self-checking bench for vga_text_overlay.

module tb_vga_text_overlay;
    logic        clk = 1'b0;
    logic        rstn;
    logic        hsync_in, vsync_in, active_in;
    logic [9:0]  px_x, px_y;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [10:0] wr_data;
    logic        clr;
    logic        busy;
    logic        cursor_en;
    logic [6:0]  cursor_col;
    logic [5:0]  cursor_row;
    logic        hsync, vsync;
    logic [2:0]  rgb;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] a_rows [8] = '{8'h18, 8'h3C, 8'h66, 8'h66, 8'h7E, 8'h66, 8'h66, 8'h00};

    always #5 clk = ~clk;

    vga_text_overlay #(.BLINK_FRAMES(2)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .active_in  (active_in),
        .px_x       (px_x),
        .px_y       (px_y),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .clr        (clr),
        .busy       (busy),
        .cursor_en  (cursor_en),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .hsync      (hsync),
        .vsync      (vsync),
        .rgb        (rgb)
    );

    task automatic pix(input int x, input int y, input logic act, output logic [2:0] c);
        @(negedge clk);
        px_x = 10'(x); px_y = 10'(y); active_in = act;
        @(negedge clk);
        active_in = 1'b0;
        repeat (3) @(negedge clk);
        c = rgb;
    endtask

    task automatic wr(input int a, input logic [10:0] d);
        @(negedge clk);
        wr_addr = 11'(a); wr_data = d; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic count_busy(output int cnt, input int wr_at);
        cnt = 0;
        while (busy && cnt < 5000) begin
            @(posedge clk); #1;
            cnt++;
            wr_en   = (cnt == wr_at);
            wr_addr = 11'd5;
            wr_data = {3'b010, 8'h41};
        end
        wr_en = 1'b0;
    endtask

    task automatic test_reset;
        int cnt;
        rstn = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1; active_in = 1'b0;
        px_x = '0; px_y = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        clr = 1'b0; cursor_en = 1'b0; cursor_col = '0; cursor_row = '0;
        repeat (3) @(negedge clk);
        n_assert++; if (hsync !== 1'b1) begin n_fail++; $display("FAIL reset_hsync got %b want 1", hsync); end
        n_assert++; if (vsync !== 1'b1) begin n_fail++; $display("FAIL reset_vsync got %b want 1", vsync); end
        n_assert++; if (rgb !== 3'b000) begin n_fail++; $display("FAIL reset_rgb got %b want 000", rgb); end
        n_assert++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy got %b want 1", busy); end
        rstn = 1'b1;
        count_busy(cnt, -1);
        n_assert++; if (cnt !== 1200) begin n_fail++; $display("FAIL reset_sweep_len got %0d want 1200", cnt); end
    endtask

    task automatic test_clear_pattern;
        int xs [8]       = '{100, 0,      639,    300,    300,    639,    320,    0};
        int ys [8]       = '{100, 100,    200,    479,    0,      479,    240,    100};
        logic acts [8]   = '{1'b1, 1'b1,  1'b1,   1'b1,   1'b1,   1'b1,   1'b1,   1'b0};
        logic [2:0] ex [8] = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000};
        logic [2:0] c;
        for (int i = 0; i < 8; i++) begin
            pix(xs[i], ys[i], acts[i], c);
            n_assert++;
            if (c !== ex[i]) begin
                n_fail++;
                $display("FAIL clear_pix(%0d,%0d,act=%b) got %b want %b", xs[i], ys[i], acts[i], c, ex[i]);
            end
        end
    endtask

    task automatic test_glyph_a;
        logic [2:0] ex [256];
        for (int i = 0; i < 256; i++) begin
            int x = i % 16;
            int y = i / 16;
            logic [7:0] r = a_rows[y/2];
            if (r[7 - x/2])           ex[i] = 3'b010;
            else if (x == 0 || y == 0) ex[i] = 3'b001;
            else                       ex[i] = 3'b000;
        end
        wr(0, {3'b010, 8'h41});
        for (int j = 0; j < 260; j++) begin
            @(negedge clk);
            if (j >= 4) begin
                n_assert++;
                if (rgb !== ex[j-4]) begin
                    n_fail++;
                    $display("FAIL glyph_a(%0d,%0d) got %b want %b", (j-4) % 16, (j-4) / 16, rgb, ex[j-4]);
                end
            end
            if (j < 256) begin
                px_x = 10'(j % 16); px_y = 10'(j / 16); active_in = 1'b1;
            end else begin
                active_in = 1'b0;
            end
        end
    endtask

    task automatic test_latency;
        @(negedge clk);
        px_x = 10'd6; px_y = 10'd0; active_in = 1'b1; hsync_in = 1'b0;
        @(negedge clk);
        active_in = 1'b0; hsync_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_assert++; if (rgb !== 3'b000) begin n_fail++; $display("FAIL latency_rgb_t3 got %b want 000", rgb); end
        n_assert++; if (hsync !== 1'b1) begin n_fail++; $display("FAIL latency_hs_t3 got %b want 1", hsync); end
        @(negedge clk);
        n_assert++; if (rgb !== 3'b010) begin n_fail++; $display("FAIL latency_rgb_t4 got %b want 010", rgb); end
        n_assert++; if (hsync !== 1'b0) begin n_fail++; $display("FAIL latency_hs_t4 got %b want 0", hsync); end
        @(negedge clk);
        n_assert++; if (rgb !== 3'b000) begin n_fail++; $display("FAIL latency_rgb_t5 got %b want 000", rgb); end
        n_assert++; if (hsync !== 1'b1) begin n_fail++; $display("FAIL latency_hs_t5 got %b want 1", hsync); end
    endtask

    task automatic test_out_of_range;
        logic [2:0] c;
        wr(1200, {3'b100, 8'hDB});
        pix(6, 0, 1'b1, c);
        n_assert++; if (c !== 3'b010) begin n_fail++; $display("FAIL oor_lit got %b want 010", c); end
        pix(8, 4, 1'b1, c);
        n_assert++; if (c !== 3'b000) begin n_fail++; $display("FAIL oor_dark got %b want 000", c); end
    endtask

    task automatic test_collision;
        logic [2:0] c;
        @(negedge clk);
        px_x = 10'd6; px_y = 10'd0; active_in = 1'b1;
        @(negedge clk);
        active_in = 1'b0; wr_addr = 11'd0; wr_data = {3'b100, 8'h41}; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_assert++; if (rgb !== 3'b010) begin n_fail++; $display("FAIL collision_old got %b want 010", rgb); end
        pix(6, 0, 1'b1, c);
        n_assert++; if (c !== 3'b100) begin n_fail++; $display("FAIL collision_new got %b want 100", c); end
    endtask

    task automatic test_clr_restart;
        int cnt;
        logic [2:0] c;
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        repeat (600) @(negedge clk);
        n_assert++; if (busy !== 1'b1) begin n_fail++; $display("FAIL clr_mid_busy got %b want 1", busy); end
        clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        count_busy(cnt, 100);
        n_assert++; if (cnt !== 1200) begin n_fail++; $display("FAIL clr_restart_len got %0d want 1200", cnt); end
        pix(84, 4, 1'b1, c);
        n_assert++; if (c !== 3'b000) begin n_fail++; $display("FAIL busy_write_dropped got %b want 000", c); end
        pix(8, 8, 1'b1, c);
        n_assert++; if (c !== 3'b000) begin n_fail++; $display("FAIL clr_cell0 got %b want 000", c); end
    endtask

    task automatic test_cursor;
        logic [2:0] c;
        logic inv;
        wr(83, {3'b010, 8'h41});
        cursor_en = 1'b1; cursor_col = 7'd3; cursor_row = 6'd2;
        for (int k = 0; k < 7; k++) begin
            if (k == 6) cursor_en = 1'b0;
            inv = (k == 2 || k == 3);
            pix(50, 40, 1'b1, c);
            n_assert++;
            if (c !== (inv ? 3'b000 : 3'b010)) begin
                n_fail++; $display("FAIL cursor_lit frame %0d got %b want %b", k, c, inv ? 3'b000 : 3'b010);
            end
            pix(48, 32, 1'b1, c);
            n_assert++;
            if (c !== (inv ? 3'b010 : 3'b000)) begin
                n_fail++; $display("FAIL cursor_dark frame %0d got %b want %b", k, c, inv ? 3'b010 : 3'b000);
            end
            if (k == 2) begin
                pix(66, 40, 1'b1, c);
                n_assert++; if (c !== 3'b000) begin n_fail++; $display("FAIL cursor_neighbour got %b want 000", c); end
            end
            @(negedge clk); vsync_in = 1'b0;
            @(negedge clk); vsync_in = 1'b1;
        end
    endtask

    task automatic test_reset_mid;
        int cnt;
        @(negedge clk);
        px_x = 10'd50; px_y = 10'd40; active_in = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
        repeat (5) @(negedge clk);
        n_assert++; if (hsync !== 1'b0) begin n_fail++; $display("FAIL pre_rst_hsync got %b want 0", hsync); end
        n_assert++; if (vsync !== 1'b0) begin n_fail++; $display("FAIL pre_rst_vsync got %b want 0", vsync); end
        n_assert++; if (rgb !== 3'b010) begin n_fail++; $display("FAIL pre_rst_rgb got %b want 010", rgb); end
        #2 rstn = 1'b0;
        #1;
        n_assert++; if (hsync !== 1'b1) begin n_fail++; $display("FAIL async_rst_hsync got %b want 1", hsync); end
        n_assert++; if (vsync !== 1'b1) begin n_fail++; $display("FAIL async_rst_vsync got %b want 1", vsync); end
        n_assert++; if (rgb !== 3'b000) begin n_fail++; $display("FAIL async_rst_rgb got %b want 000", rgb); end
        n_assert++; if (busy !== 1'b1) begin n_fail++; $display("FAIL async_rst_busy got %b want 1", busy); end
        @(negedge clk);
        active_in = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
        count_busy(cnt, -1);
        n_assert++; if (cnt !== 1200) begin n_fail++; $display("FAIL rst_mid_sweep_len got %0d want 1200", cnt); end
    endtask

    initial begin
        test_reset();
        test_clear_pattern();
        test_glyph_a();
        test_latency();
        test_out_of_range();
        test_collision();
        test_clr_restart();
        test_cursor();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
